// File: rtl/gpr_write_arbiter.sv
// GPR write-port arbiter: pipeline writeback has priority; long-unit results queue in a
// small FIFO, drain into idle write-port cycles, and raise a stall request if starved.
module gpr_write_arbiter #(
   parameter int FIFO_DEPTH   = 2,
   parameter int STARVE_LIMIT = 4,
   parameter int DATA_W       = 32,
   parameter int ADDR_W       = 5
) (
   input  logic              CLK,
   input  logic              RST_N,
   input  logic              PipeWrite,
   input  logic [ADDR_W-1:0] PipeReg,
   input  logic [DATA_W-1:0] PipeData,
   input  logic              LongValid,
   input  logic [ADDR_W-1:0] LongReg,
   input  logic [DATA_W-1:0] LongData,
   output logic              LongReady,
   output logic              RegWrite,
   output logic [ADDR_W-1:0] WriteRegisterSelect,
   output logic [DATA_W-1:0] WriteData,
   output logic [31:0]       Pending,
   output logic              StallReq
);

   localparam int PTR_W    = $clog2(FIFO_DEPTH);
   localparam int CNT_W    = PTR_W + 1;
   localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

   localparam logic [CNT_W-1:0]    DEPTH_C  = CNT_W'(FIFO_DEPTH);
   localparam logic [STARVE_W-1:0] STARVE_C = STARVE_W'(STARVE_LIMIT);

   logic [ADDR_W-1:0]   fifoReg  [FIFO_DEPTH];
   logic [DATA_W-1:0]   fifoData [FIFO_DEPTH];
   logic [FIFO_DEPTH-1:0] fifoValid;
   logic [PTR_W-1:0]    rdPtr;
   logic [PTR_W-1:0]    wrPtr;
   logic [CNT_W-1:0]    count;
   logic [STARVE_W-1:0] starveCnt;
   logic [STARVE_W-1:0] starveNext;
   logic                stallQ;

   logic                pipeGrant;
   logic                fifoEmpty;
   logic                headValid;
   logic                headBlocked;
   logic                pushEn;
   logic                popEn;
   logic [31:0]         pendingVec;

   assign pipeGrant   = PipeWrite && (PipeReg != '0);
   assign fifoEmpty   = (count == '0);
   assign headValid   = !fifoEmpty && fifoValid[rdPtr];
   assign headBlocked = headValid && pipeGrant;

   // Readiness looks only at the registered count, so a same-cycle pop never frees a slot.
   assign LongReady = RST_N && (count < DEPTH_C);
   assign pushEn    = LongValid && LongReady && (LongReg != '0);
   assign popEn     = !fifoEmpty && !pipeGrant;

   assign RegWrite = RST_N && (pipeGrant || headValid);
   assign StallReq = stallQ;

   always_comb begin
      WriteRegisterSelect = '0;
      WriteData           = '0;
      if (pipeGrant) begin
         WriteRegisterSelect = PipeReg;
         WriteData           = PipeData;
      end else if (headValid) begin
         WriteRegisterSelect = fifoReg[rdPtr];
         WriteData           = fifoData[rdPtr];
      end
   end

   always_comb begin
      pendingVec = '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
         if (fifoValid[PTR_W'(i)])
            pendingVec[fifoReg[PTR_W'(i)]] = 1'b1;
      end
   end

   assign Pending = RST_N ? pendingVec : '0;

   always_comb begin
      starveNext = starveCnt;
      if (popEn || fifoEmpty)
         starveNext = '0;
      else if (headBlocked && (starveCnt != STARVE_C))
         starveNext = starveCnt + STARVE_W'(1);
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         fifoValid <= '0;
         rdPtr     <= '0;
         wrPtr     <= '0;
         count     <= '0;
         starveCnt <= '0;
         stallQ    <= 1'b0;
      end else begin
         // Kill first, then pop/push, so a same-cycle push of the same register survives.
         if (pipeGrant) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
               if (fifoReg[PTR_W'(i)] == PipeReg)
                  fifoValid[PTR_W'(i)] <= 1'b0;
            end
         end
         if (popEn) begin
            fifoValid[rdPtr] <= 1'b0;
            rdPtr            <= rdPtr + PTR_W'(1);
         end
         if (pushEn) begin
            fifoReg[wrPtr]   <= LongReg;
            fifoData[wrPtr]  <= LongData;
            fifoValid[wrPtr] <= 1'b1;
            wrPtr            <= wrPtr + PTR_W'(1);
         end
         count     <= count + CNT_W'(pushEn) - CNT_W'(popEn);
         starveCnt <= starveNext;
         if (popEn)
            stallQ <= 1'b0;
         else if (headBlocked && (starveNext == STARVE_C))
            stallQ <= 1'b1;
      end
   end

endmodule

// File: doc/gpr_write_arbiter.md
Name: gpr_write_arbiter

Overview:
Shares the single GPR write port (RegWrite / WriteRegisterSelect / WriteData) between two producers: the in-order pipeline writeback stage and a long-latency unit (mult/div, HI/LO moves, multi-cycle loads). Pipeline writes always win. Long-unit results wait in a small FIFO and drain into free write-port cycles. The block also exports a pending-write bitmap for the hazard unit, and a starvation stall request so queued results cannot be blocked indefinitely.

Parameters:
FIFO_DEPTH, 2, number of long-unit results buffered (power of two, >=2)
STARVE_LIMIT, 4, consecutive blocked cycles of a valid FIFO head before StallReq asserts
DATA_W, 32, register data width
ADDR_W, 5, register index width

Ports:
CLK  in  1  system clock, all state updates on posedge
RST_N  in  1  synchronous reset, active low
PipeWrite  in  1  pipeline WB requests a write this cycle; no back-pressure possible
PipeReg  in  ADDR_W  pipeline destination register
PipeData  in  DATA_W  pipeline write data
LongValid  in  1  long unit offers a result
LongReg  in  ADDR_W  long-unit destination register
LongData  in  DATA_W  long-unit result
LongReady  out  1  arbiter can accept a long result this cycle
RegWrite  out  1  to GPR RegWrite
WriteRegisterSelect  out  ADDR_W  to GPR
WriteData  out  DATA_W  to GPR
Pending  out  32  bit r = a valid queued write to register r exists
StallReq  out  1  request to hazard unit: insert a WB bubble next cycle

Behaviour:
- Reset (RST_N=0 at posedge): FIFO emptied, all entries invalid, starve counter=0, StallReq=0. While RST_N=0, the following are forced low combinationally: LongReady=0, RegWrite=0, Pending=0. Reset mid-drain discards queued results; no GPR write occurs.
- Long acceptance: LongReady = RST_N && (count < FIFO_DEPTH). Push happens on a posedge with LongValid && LongReady.
  - LongReg==0: the result is accepted and discarded (not stored, count unchanged).
  - An entry is not visible at the head until the cycle after its push (no bypass).
  - LongReady depends only on count; a pop in the same cycle does not free a slot for that cycle.
- Write-port selection is combinational each cycle:
  - PipeWrite && PipeReg!=0: RegWrite=1, WriteRegisterSelect=PipeReg, WriteData=PipeData. The FIFO head is blocked.
  - Otherwise, if the FIFO is non-empty and the head is valid: drive the head's reg/data with RegWrite=1, and pop at the posedge.
  - Otherwise, if the FIFO is non-empty and the head is invalid (killed): pop at the posedge with RegWrite=0.
  - Otherwise: RegWrite=0; WriteRegisterSelect and WriteData are don't-care, driven 0.
  - PipeWrite with PipeReg==0 counts as no request; the port is free for the FIFO.
- WAW kill: on a posedge where a pipeline write to r (r!=0) is granted, every queued valid entry with reg==r is marked invalid. The pipeline write is architecturally younger. A push of reg r in that same cycle is not killed.
- Pending: the OR of one-hot(reg) over valid entries, driven combinationally from current state. Newly pushed entries appear the cycle after the push. Killed or popped entries clear the cycle after.
- Starvation:
  - The counter increments on each posedge where the FIFO head is valid and blocked by a pipeline write. It resets to 0 on any head pop, or when the FIFO is empty.
  - StallReq is registered. It sets on the posedge where the counter reaches STARVE_LIMIT, and clears on the posedge where the head pops.
  - The pipeline still wins if it writes while StallReq=1; no error is raised.
- Occupancy count is ceil(log2(FIFO_DEPTH))+1 bits. Read/write pointers wrap modulo FIFO_DEPTH.

Test Plan:
- Reset: hold RST_N=0 for 3 cycles with LongValid=1 and PipeWrite=1 -> RegWrite=0, LongReady=0, Pending=0. After release: LongReady=1, count=0.
- Priority: push long r5=0x11 at cycle 0; PipeWrite r3=0xAA in cycles 1-2 -> GPR writes r3 in cycles 1-2 and r5=0x11 in cycle 3. Pending[5]=1 in cycles 1-3, then 0 in cycle 4.
- Full/back-pressure: push r6 and r7 with PipeWrite held high -> LongReady=0 after the second push. Drop PipeWrite -> r6, then r7 written on consecutive cycles; LongReady returns to 1 the cycle after the first pop.
- Register 0: long push r0=0xFFFF and PipeWrite r0 -> no GPR write, Pending stays 0, and a queued r9 drains in the PipeWrite-r0 cycle.
- WAW kill: queue r8=0x1; PipeWrite r8=0x2 while the entry is blocked -> entry killed, Pending[8] clears next cycle, GPR r8 ends at 0x2, and the invalid head pops with RegWrite=0.
- Starvation: queue r4; hold PipeWrite r1 continuously -> StallReq=1 after 4 blocked cycles. Drop PipeWrite for one cycle -> r4 written, StallReq=0 on the next cycle.
